// File: rtl/demux2_4_buf.sv
// 1-to-2 demultiplexer with a single-word valid/ready buffer on each output
// port and a free-running delivered-word counter per port.
module demux2_4_buf #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] a_data,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] b_data,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [CNT_W-1:0] a_count,
  output logic [CNT_W-1:0] b_count
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } buf_state_t;

  buf_state_t a_state;
  buf_state_t b_state;

  logic a_out_xfer;
  logic b_out_xfer;
  logic a_in_xfer;
  logic b_in_xfer;

  assign a_valid = (a_state == FULL);
  assign b_valid = (b_state == FULL);

  assign a_out_xfer = a_valid & a_ready;
  assign b_out_xfer = b_valid & b_ready;

  // A full buffer can still accept when it is draining this same cycle.
  assign in_ready = in_sel ? (~b_valid | b_ready) : (~a_valid | a_ready);

  assign a_in_xfer = in_valid & in_ready & ~in_sel;
  assign b_in_xfer = in_valid & in_ready &  in_sel;

  always_ff @(posedge clk) begin
    if (reset) begin
      a_state <= EMPTY;
      a_data  <= '0;
      a_count <= '0;
    end else begin
      case (a_state)
        EMPTY: begin
          if (a_in_xfer) begin
            a_state <= FULL;
            a_data  <= in_data;
          end
        end
        FULL: begin
          if (a_in_xfer) begin
            a_data <= in_data;
          end else if (a_out_xfer) begin
            a_state <= EMPTY;
          end
        end
        default: a_state <= EMPTY;
      endcase
      if (a_out_xfer) begin
        a_count <= a_count + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      b_state <= EMPTY;
      b_data  <= '0;
      b_count <= '0;
    end else begin
      case (b_state)
        EMPTY: begin
          if (b_in_xfer) begin
            b_state <= FULL;
            b_data  <= in_data;
          end
        end
        FULL: begin
          if (b_in_xfer) begin
            b_data <= in_data;
          end else if (b_out_xfer) begin
            b_state <= EMPTY;
          end
        end
        default: b_state <= EMPTY;
      endcase
      if (b_out_xfer) begin
        b_count <= b_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/demux2_4_buf.md
DEMUX2_4_BUF -- requirements
Module: demux2_4_buf

Interface
REQ-001 Parameter WIDTH, default 4, data word width in bits.
REQ-002 Parameter CNT_W, default 8, width of each delivered-word counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-005 in_data  input  WIDTH  word to route.
REQ-006 in_sel  input  1  destination select: 0 = port A, 1 = port B.
REQ-007 in_valid  input  1  in_data/in_sel valid this cycle.
REQ-008 in_ready  output  1  block accepts the offered word this cycle.
REQ-009 a_data  output  WIDTH  port A buffered word.
REQ-010 a_valid  output  1  a_data holds an undelivered word.
REQ-011 a_ready  input  1  port A consumer accepts a_data this cycle.
REQ-012 b_data  output  WIDTH  port B buffered word.
REQ-013 b_valid  output  1  b_data holds an undelivered word.
REQ-014 b_ready  input  1  port B consumer accepts b_data this cycle.
REQ-015 a_count  output  CNT_W  number of words delivered on port A.
REQ-016 b_count  output  CNT_W  number of words delivered on port B.

Function
REQ-017 Each output port SHALL own a one-word buffer with a two-state FSM: EMPTY (x_valid=0) and FULL (x_valid=1).
REQ-018 Input transfer SHALL occur on a cycle where in_valid=1 and in_ready=1; output transfer on port X SHALL occur where x_valid=1 and x_ready=1.
REQ-019 in_ready SHALL be combinational: 1 when the port chosen by in_sel is EMPTY or is completing an output transfer that same cycle; otherwise 0.
REQ-020 in_ready SHALL NOT depend on in_valid; it MAY depend on in_sel, x_valid and x_ready of the selected port.
REQ-021 An accepted word SHALL appear on the selected port's x_data with x_valid=1 on the next rising edge (latency 1 cycle).
REQ-022 The non-selected port SHALL be unaffected by an input transfer.
REQ-023 EMPTY -> FULL on input transfer to that port; FULL -> EMPTY on output transfer with no simultaneous input transfer to that port; FULL -> FULL with new data on simultaneous output and input transfer to that port.
REQ-024 While x_valid=1 and x_ready=0, x_data SHALL remain stable.
REQ-025 x_data SHALL hold its last value when EMPTY (no requirement to clear).
REQ-026 x_count SHALL increment by 1 on each output transfer on port X, wrapping from 2^CNT_W-1 to 0.
REQ-027 Words to the same port SHALL be delivered in acceptance order; no ordering is defined between ports.
REQ-028 No word SHALL be dropped or duplicated outside reset.
REQ-029 A stalled port SHALL NOT block input transfers addressed to the other port.

Reset
REQ-030 While reset=1 at a rising edge: a_valid=0, b_valid=0, a_data=0, b_data=0, a_count=0, b_count=0 after that edge.
REQ-031 Reset SHALL take priority over any simultaneous input or output transfer; buffered and in-flight words are discarded and not counted.
REQ-032 During reset, in_ready SHALL be driven as per REQ-019 from post-reset state only after the edge; transfers offered in the reset cycle are lost.

Verification
REQ-033 Reset, then in_data=4'b0001, in_sel=0, in_valid=1 one cycle, a_ready=1 -> next cycle a_valid=1, a_data=0001, b_valid=0; following cycle a_count=1.
REQ-034 a_ready=0; send 0010 to A, then offer 0011 to A -> in_ready=0, a_data stays 0010; raise a_ready -> 0010 delivered, 0011 accepted same cycle, a_data=0011 next cycle.
REQ-035 Port A stalled full (a_ready=0); offer 0100 with in_sel=1 -> in_ready=1, b_data=0100, b_valid=1 next cycle; a_data unchanged.
REQ-036 Both ready=1, stream 16 words alternating in_sel 0/1 every cycle -> in_ready=1 throughout, a_count=8, b_count=8, each port order preserved.
REQ-037 CNT_W=2: deliver 5 words on B -> b_count sequence 1,2,3,0,1.
REQ-038 Both ports FULL, assert reset one cycle with in_valid=1 -> a_valid=b_valid=0, counts=0, offered word not delivered.
